// File: rtl/axi_rd_slave.sv
// rtl/axi_rd_slave.sv - AXI read slave returning address/index pattern beats; AXI_RD_SLAVE_STALL_EN adds LFSR-driven inter-beat gaps
module axi_rd_slave #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int AR_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);
    localparam int PTR_W = $clog2(AR_DEPTH);

    typedef enum logic {S_IDLE, S_BURST} state_t;
    state_t state;

    logic [ID_WIDTH-1:0]   q_id    [AR_DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr  [AR_DEPTH];
    logic [7:0]            q_len   [AR_DEPTH];
    logic [2:0]            q_size  [AR_DEPTH];
    logic [1:0]            q_burst [AR_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  empty, push, pop, last_hs, gap;

    logic [ADDR_WIDTH-1:0] cur_addr, nxt_addr;
    logic [7:0]            cur_len, beat, nxt_beat;
    logic [2:0]            cur_size;
    logic [1:0]            cur_burst;

    assign empty   = (count == '0);
    assign arready = rst_n && (count != (PTR_W+1)'(AR_DEPTH));
    assign push    = arvalid && arready;
    assign last_hs = rvalid && rready && rlast;
    assign pop     = !empty && ((state == S_IDLE) || last_hs);

    assign nxt_beat = beat + 8'd1;
    assign nxt_addr = (cur_burst == 2'b01)
                    ? cur_addr + ({{(ADDR_WIDTH-1){1'b0}}, 1'b1} << cur_size)
                    : cur_addr;

    // Error bursts carry all-zero data; otherwise {index, address} in the low bits
    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] idx,
                                                        input logic err);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        if (!err) begin
            d[ADDR_WIDTH-1:0]          = a;
            d[ADDR_WIDTH+7:ADDR_WIDTH] = idx;
        end
        return d;
    endfunction

`ifdef AXI_RD_SLAVE_STALL_EN
    logic [7:0] lfsr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign gap = (lfsr[1:0] == 2'b00);
`else
    assign gap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            q_id[wr_ptr]    <= arid;
            q_addr[wr_ptr]  <= araddr;
            q_len[wr_ptr]   <= arlen;
            q_size[wr_ptr]  <= arsize;
            q_burst[wr_ptr] <= arburst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rid       <= '0;
            rdata     <= '0;
            rresp     <= 2'b00;
            cur_addr  <= '0;
            cur_len   <= '0;
            cur_size  <= '0;
            cur_burst <= '0;
            beat      <= '0;
        end else if (pop) begin
            // Covers both the idle start and the bubble-free chain after a last beat
            state     <= S_BURST;
            rvalid    <= 1'b1;
            rid       <= q_id[rd_ptr];
            rdata     <= beat_data(q_addr[rd_ptr], 8'd0, q_burst[rd_ptr][1]);
            rresp     <= q_burst[rd_ptr][1] ? 2'b10 : 2'b00;
            rlast     <= (q_len[rd_ptr] == 8'd0);
            cur_addr  <= q_addr[rd_ptr];
            cur_len   <= q_len[rd_ptr];
            cur_size  <= q_size[rd_ptr];
            cur_burst <= q_burst[rd_ptr];
            beat      <= 8'd0;
        end else if (state == S_BURST) begin
            if (!rvalid) begin
                rvalid <= !gap;
            end else if (rready) begin
                if (rlast) begin
                    state  <= S_IDLE;
                    rvalid <= 1'b0;
                    rlast  <= 1'b0;
                end else begin
                    rvalid   <= !gap;
                    cur_addr <= nxt_addr;
                    beat     <= nxt_beat;
                    rdata    <= beat_data(nxt_addr, nxt_beat, cur_burst[1]);
                    rlast    <= (nxt_beat == cur_len);
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_slave.sv
// tb/tb_axi_rd_slave.sv - randomized scoreboard bench for axi_rd_slave
module tb_axi_rd_slave;
    localparam int IW = 4, AW = 32, DW = 64, DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;

    axi_rd_slave #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AR_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mb;
    int checks = 0, errors = 0;
    int nbeats = 0, nlast = 0, first_cyc = 0, last_cyc = 0, cyc = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] p_data;
    logic [7:0]    p_ctl;
    logic          done;
    int            total;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expand one accepted AR into its expected beats
    task automatic model_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        beat_t b;
        logic [AW-1:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = (burst == 2'b00) ? addr : addr + 32'(i) * (32'd1 << size);
            b.id   = id;
            b.resp = burst[1] ? 2'b10 : 2'b00;
            b.data = burst[1] ? '0 : {24'd0, 8'(i), a};
            b.last = (i == int'(len));
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("r_hold_valid", 64'(rvalid), 64'd1);
                chk("r_hold_data", rdata, p_data);
                chk("r_hold_ctl", 64'({rid, rresp, rlast}), 64'(p_ctl));
            end
            if (arvalid && arready) model_ar(arid, araddr, arlen, arsize, arburst);
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    chk("r_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    mb = exp_q.pop_front();
                    chk("r_id", 64'(rid), 64'(mb.id));
                    chk("r_data", rdata, mb.data);
                    chk("r_resp", 64'(rresp), 64'(mb.resp));
                    chk("r_last", 64'(rlast), 64'(mb.last));
                end
                if (nbeats == 0) first_cyc = cyc;
                last_cyc = cyc;
                nbeats++;
                if (rlast) nlast++;
            end
            hold_prev = rvalid && !rready;
            p_data    = rdata;
            p_ctl     = 8'({rid, rresp, rlast});
        end
    end

    task automatic send_ar(input int id, input logic [AW-1:0] addr, input int len,
                           input int size, input int burst);
        int t = 0;
        arid    = IW'(id);
        araddr  = addr;
        arlen   = 8'(len);
        arsize  = 3'(size);
        arburst = 2'(burst);
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("ar_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || rvalid) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        nbeats = 0;
        nlast  = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rid", 64'(rid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arready_after_rst", 64'(arready), 64'd1);
        @(posedge clk);
        #1;

        // Basic INCR burst with minimum-latency check
        rready = 1'b1;
        clear_counts();
        send_ar(2, 32'h100, 3, 3, 1);
        @(negedge clk);
        chk("lat_early", 64'(rvalid), 64'd0);
        @(negedge clk);
        chk("lat_first", 64'(rvalid), 64'd1);
        wait_idle();
        chk("t1_beats", 64'(nbeats), 64'd4);
        chk("t1_rlast", 64'(nlast), 64'd1);

        // Fill the AR queue, then stream six bursts back to back
        rready = 1'b0;
        clear_counts();
        for (int i = 1; i <= 5; i++) send_ar(i, 32'h1000 * i, 4, 2, 1);
        @(negedge clk);
        chk("ar_full", 64'(arready), 64'd0);
        @(posedge clk);
        #1 rready = 1'b1;
        send_ar(6, 32'h6000, 4, 2, 1);
        wait_idle();
        chk("t2_beats", 64'(nbeats), 64'd30);
        chk("t2_rlast", 64'(nlast), 64'd6);
        chk("t2_contig", 64'(last_cyc - first_cyc + 1), 64'd30);

        // rready toggling every cycle
        rready = 1'b1;
        clear_counts();
        send_ar(3, 32'h300, 7, 3, 1);
        for (int t = 0; t < 60 && nbeats < 8; t++) begin
            @(posedge clk);
            #1 rready = !rready;
        end
        rready = 1'b1;
        wait_idle();
        chk("t3_beats", 64'(nbeats), 64'd8);

        // FIXED burst and unsupported burst type
        clear_counts();
        send_ar(4, 32'h40, 2, 3, 0);
        send_ar(5, 32'h80, 2, 3, 3);
        wait_idle();
        chk("t4_beats", 64'(nbeats), 64'd6);
        chk("t4_rlast", 64'(nlast), 64'd2);

        // Reset mid-burst with two bursts queued
        rready = 1'b0;
        send_ar(7, 32'h500, 7, 3, 1);
        send_ar(8, 32'h600, 3, 3, 1);
        send_ar(9, 32'h700, 3, 3, 1);
        clear_counts();
        rready = 1'b1;
        for (int t = 0; t < 100 && nbeats < 2; t++) begin
            @(negedge clk);
            #2;
        end
        chk("t5_reached_beat2", 64'(nbeats >= 2), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
        chk("mid_rst_rdata", rdata, 64'd0);
        chk("mid_rst_rid", 64'(rid), 64'd0);
        chk("mid_rst_rlast", 64'(rlast), 64'd0);
        chk("mid_rst_rresp", 64'(rresp), 64'd0);
        chk("mid_rst_arready", 64'(arready), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_counts();
        send_ar(1, 32'h200, 0, 3, 1);
        wait_idle();
        repeat (20) @(posedge clk);
        #1;
        chk("t5_post_rst_beats", 64'(nbeats), 64'd1);

        // Address wrap
        clear_counts();
        send_ar(10, 32'hFFFF_FFF8, 1, 3, 1);
        wait_idle();
        chk("t6_beats", 64'(nbeats), 64'd2);

        // Random traffic with random backpressure
        clear_counts();
        total = 0;
        done = 1'b0;
        fork
            begin
                while (!done) begin
                    rready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                rready = 1'b1;
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    int len;
                    len = $urandom_range(0, 15);
                    total += len + 1;
                    send_ar($urandom_range(0, 15), $urandom, len,
                            $urandom_range(0, 3), $urandom_range(0, 3));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                done = 1'b1;
            end
        join
        wait_idle();
        chk("rand_beats", 64'(nbeats), 64'(total));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_rd_slave.md
AXI_RD_SLAVE -- requirements
Module: axi_rd_slave

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AR/R ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, R data width; DATA_WIDTH >= ADDR_WIDTH+8 is required.
REQ-004 SHALL have parameter AR_DEPTH, default 4, AR queue entries (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port arid  input  ID_WIDTH  read request ID.
REQ-008 SHALL have port araddr  input  ADDR_WIDTH  burst start address.
REQ-009 SHALL have port arlen  input  8  beats minus one.
REQ-010 SHALL have port arsize  input  3  log2 bytes per beat.
REQ-011 SHALL have port arburst  input  2  00 FIXED, 01 INCR, 10/11 unsupported.
REQ-012 SHALL have port arvalid  input  1  AR valid.
REQ-013 SHALL have port arready  output  1  AR ready.
REQ-014 SHALL have port rid  output  ID_WIDTH  ID of current beat.
REQ-015 SHALL have port rdata  output  DATA_WIDTH  beat data.
REQ-016 SHALL have port rresp  output  2  00 OKAY, 10 SLVERR.
REQ-017 SHALL have port rlast  output  1  final beat of burst.
REQ-018 SHALL have port rvalid  output  1  R valid.
REQ-019 SHALL have port rready  input  1  R ready from master.

Function
REQ-020 SHALL push {arid, araddr, arlen, arsize, arburst} into an AR_DEPTH-entry in-order FIFO on each edge with arvalid && arready.
REQ-021 SHALL drive arready = FIFO not full (combinational from count); full FIFO blocks push regardless of a same-cycle pop.
REQ-022 SHALL run FSM IDLE/BURST: IDLE with FIFO non-empty pops the head at the next edge, loads burst registers, sets rvalid=1, beat=0, enters BURST.
REQ-023 SHALL give minimum latency: AR handshake at edge N into empty idle block -> rvalid high after edge N+1.
REQ-024 SHALL, in BURST, advance only on rvalid && rready; rid/rdata/rresp/rlast held stable while rvalid && !rready.
REQ-025 SHALL compute beat address: INCR addr += (1 << arsize), FIXED addr constant; address wraps modulo 2^ADDR_WIDTH.
REQ-026 SHALL drive rdata[ADDR_WIDTH-1:0] = beat address, rdata[ADDR_WIDTH+7:ADDR_WIDTH] = beat index, remaining bits 0.
REQ-027 SHALL, for arburst 10 or 11, return arlen+1 beats with rresp=10 and rdata=0; otherwise rresp=00.
REQ-028 SHALL assert rlast exactly on beat index == arlen (arlen=0 -> first beat has rlast=1).
REQ-029 SHALL, on last-beat handshake with FIFO non-empty, load the next burst on the same edge, keeping rvalid high (no bubble); with FIFO empty clear rvalid/rlast and go IDLE.
REQ-030 SHALL return bursts in AR acceptance order; arlen=255 yields 256 beats.

Reset
REQ-031 SHALL, while rst_n=0, force immediately: arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, FIFO empty, FSM IDLE; mid-burst reset discards all in-flight and queued bursts.
REQ-032 SHALL raise arready the first cycle after rst_n deassertion.

Configuration
REQ-033 SHALL, with macro AXI_RD_SLAVE_STALL_EN defined, hold rvalid low after each non-last beat handshake while lfsr[1:0]==2'b00 (8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, reset seed 8'hA5, advancing every cycle); rvalid never drops before its handshake.
REQ-034 SHALL, without AXI_RD_SLAVE_STALL_EN, contain no LFSR and insert no gaps between beats.

Verification
REQ-035 SHALL cover: INCR arid=2 araddr=0x100 arlen=3 arsize=3, rready=1 -> 4 beats rdata low 0x100/0x108/0x110/0x118, index 0..3, rid=2, rresp=00, rlast on 4th only.
REQ-036 SHALL cover: 6 back-to-back ARs arlen=4, ids 1..6 -> arready drops when queue holds 4, 30 contiguous beats (stall macro off), ids in order, 6 rlast pulses.
REQ-037 SHALL cover: rready toggling 1/0 each cycle during arlen=7 burst -> outputs stable during stalls, exactly 8 handshakes.
REQ-038 SHALL cover: FIXED araddr=0x40 arlen=2 -> 3 beats address 0x40; arburst=11 arlen=2 -> 3 beats rresp=10 rdata=0.
REQ-039 SHALL cover: rst_n low at beat 2 of arlen=7 with 2 queued -> outputs zero immediately; post-reset AR araddr=0x200 returns beat 0 of new burst only.
REQ-040 SHALL cover: INCR araddr=0xFFFF_FFF8 arlen=1 arsize=3 -> beats 0xFFFF_FFF8 then 0x0000_0000.
